// File: rtl/text_cursor_ctrl_if.sv
// Byte-in / cell-write bundle between the UART receiver side and the text
// cursor controller. The controller uses the slave view; whoever feeds it
// bytes and watches the buffer writes uses the master view.
interface text_cursor_ctrl_if #(
  parameter int COLS   = 80,
  parameter int ROWS   = 30,
  parameter int ADDR_W = 12
);
  localparam int COL_W = $clog2(COLS);
  localparam int ROW_W = $clog2(ROWS);

  logic [7:0]        data_in;
  logic              data_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_char;
  logic [COL_W-1:0]  cursor_col;
  logic [ROW_W-1:0]  cursor_row;
  logic              busy;
  logic              overrun;

  modport master (
    output data_in, data_ready,
    input  wr_en, wr_addr, wr_char, cursor_col, cursor_row, busy, overrun
  );

  modport slave (
    input  data_in, data_ready,
    output wr_en, wr_addr, wr_char, cursor_col, cursor_row, busy, overrun
  );
endinterface

// File: rtl/text_cursor_ctrl.sv
// Terminal-style write controller. Turns received bytes into single-cell
// writes for a COLS x ROWS character buffer, tracks the cursor, and runs
// row / screen blanking sweeps. A one-byte pending slot absorbs a byte that
// arrives while a sweep is running; a second such byte is dropped and
// flagged on overrun. Every output comes straight from a register.
module text_cursor_ctrl #(
  parameter int COLS   = 80,
  parameter int ROWS   = 30,
  parameter int ADDR_W = 12
) (
  input  logic                clk,
  input  logic                reset,
  text_cursor_ctrl_if.slave   bus
);

  localparam int COL_W = $clog2(COLS);
  localparam int ROW_W = $clog2(ROWS);
  // One spare bit so a full-screen count never aliases to zero.
  localparam int CNT_W = ADDR_W + 1;

  localparam logic [7:0] CH_SPACE = 8'h20;
  localparam logic [7:0] CH_BS    = 8'h08;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_FF    = 8'h0C;
  localparam logic [7:0] CH_CR    = 8'h0D;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ROW_CLR = 2'd1,
    SCR_CLR = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [COL_W-1:0]  r_col,       w_col_nxt;
  logic [ROW_W-1:0]  r_row,       w_row_nxt;
  logic              r_wr_en,     w_wr_en_nxt;
  logic [ADDR_W-1:0] r_wr_addr,   w_wr_addr_nxt;
  logic [7:0]        r_wr_char,   w_wr_char_nxt;
  logic              r_busy,      w_busy_nxt;
  logic              r_overrun,   w_overrun_nxt;
  logic              r_pend_vld,  w_pend_vld_nxt;
  logic [7:0]        r_pend_data, w_pend_data_nxt;
  // Sweep engine: next cell to blank and how many cells remain.
  logic [ADDR_W-1:0] r_sw_addr,   w_sw_addr_nxt;
  logic [CNT_W-1:0]  r_sw_left,   w_sw_left_nxt;

  // Byte chosen for decode this cycle (pending slot has priority).
  logic              w_dec_go;
  logic [7:0]        w_dec_byte;
  logic [ROW_W-1:0]  w_row_inc;

  // Row after the current one; there is no scrolling, the last row wraps to 0.
  function automatic logic [ROW_W-1:0] f_row_inc(input logic [ROW_W-1:0] row);
    return (row == ROW_W'(ROWS - 1)) ? '0 : row + ROW_W'(1);
  endfunction

  // Linear buffer address of a cell.
  function automatic logic [ADDR_W-1:0] f_cell_addr(input logic [ROW_W-1:0] row,
                                                    input logic [COL_W-1:0] col);
    return ADDR_W'(COLS) * ADDR_W'(row) + ADDR_W'(col);
  endfunction

  function automatic logic f_printable(input logic [7:0] b);
    return (b >= 8'h20) && (b <= 8'h7E);
  endfunction

  assign w_row_inc = f_row_inc(r_row);

  // Next-state, next-output and pending-slot logic for the controller FSM.
  always_comb begin
    w_state_nxt     = r_state;
    w_col_nxt       = r_col;
    w_row_nxt       = r_row;
    w_wr_en_nxt     = 1'b0;
    w_wr_addr_nxt   = r_wr_addr;
    w_wr_char_nxt   = r_wr_char;
    w_busy_nxt      = 1'b0;
    w_overrun_nxt   = 1'b0;
    w_pend_vld_nxt  = r_pend_vld;
    w_pend_data_nxt = r_pend_data;
    w_sw_addr_nxt   = r_sw_addr;
    w_sw_left_nxt   = r_sw_left;
    w_dec_go        = 1'b0;
    w_dec_byte      = r_pend_data;

    // Byte source selection and pending-slot bookkeeping.
    if (r_state == IDLE) begin
      if (r_pend_vld) begin
        // Held byte goes first; a byte arriving now takes its place.
        w_dec_go   = 1'b1;
        w_dec_byte = r_pend_data;
        if (bus.data_ready) begin
          w_pend_data_nxt = bus.data_in;
        end else begin
          w_pend_vld_nxt  = 1'b0;
        end
      end else if (bus.data_ready) begin
        w_dec_go   = 1'b1;
        w_dec_byte = bus.data_in;
      end
    end else if (bus.data_ready) begin
      if (r_pend_vld) begin
        w_overrun_nxt = 1'b1;
      end else begin
        w_pend_vld_nxt  = 1'b1;
        w_pend_data_nxt = bus.data_in;
      end
    end

    case (r_state)
      IDLE: begin
        if (w_dec_go) begin
          if (f_printable(w_dec_byte)) begin
            w_wr_en_nxt   = 1'b1;
            w_wr_addr_nxt = f_cell_addr(r_row, r_col);
            w_wr_char_nxt = w_dec_byte;
            if (r_col == COL_W'(COLS - 1)) begin
              // Line wrap: the character write goes out first, the blanking
              // of the new row starts on the following cycle.
              w_col_nxt     = '0;
              w_row_nxt     = w_row_inc;
              w_sw_addr_nxt = f_cell_addr(w_row_inc, '0);
              w_sw_left_nxt = CNT_W'(COLS);
              w_state_nxt   = ROW_CLR;
            end else begin
              w_col_nxt     = r_col + COL_W'(1);
            end
          end else begin
            case (w_dec_byte)
              CH_CR: begin
                w_col_nxt = '0;
              end
              CH_LF: begin
                // First blank cell is issued right away, the rest by the sweep.
                w_col_nxt     = '0;
                w_row_nxt     = w_row_inc;
                w_wr_en_nxt   = 1'b1;
                w_wr_addr_nxt = f_cell_addr(w_row_inc, '0);
                w_wr_char_nxt = CH_SPACE;
                w_busy_nxt    = 1'b1;
                w_sw_addr_nxt = f_cell_addr(w_row_inc, '0) + ADDR_W'(1);
                w_sw_left_nxt = CNT_W'(COLS - 1);
                w_state_nxt   = ROW_CLR;
              end
              CH_BS: begin
                // Backspace never crosses to the previous row.
                if (r_col != '0) begin
                  w_col_nxt     = r_col - COL_W'(1);
                  w_wr_en_nxt   = 1'b1;
                  w_wr_addr_nxt = f_cell_addr(r_row, r_col - COL_W'(1));
                  w_wr_char_nxt = CH_SPACE;
                end
              end
              CH_FF: begin
                w_col_nxt     = '0;
                w_row_nxt     = '0;
                w_wr_en_nxt   = 1'b1;
                w_wr_addr_nxt = '0;
                w_wr_char_nxt = CH_SPACE;
                w_busy_nxt    = 1'b1;
                w_sw_addr_nxt = ADDR_W'(1);
                w_sw_left_nxt = CNT_W'(COLS * ROWS - 1);
                w_state_nxt   = SCR_CLR;
              end
              default: begin
              end
            endcase
          end
        end
      end

      ROW_CLR, SCR_CLR: begin
        // Both sweeps blank consecutive ascending cells; only the extent differs.
        if (r_sw_left == '0) begin
          w_state_nxt = IDLE;
        end else begin
          w_wr_en_nxt   = 1'b1;
          w_wr_addr_nxt = r_sw_addr;
          w_wr_char_nxt = CH_SPACE;
          w_busy_nxt    = 1'b1;
          w_sw_addr_nxt = r_sw_addr + ADDR_W'(1);
          w_sw_left_nxt = r_sw_left - CNT_W'(1);
        end
      end

      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Cursor, output and pending-valid registers; reset aborts any sweep.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_col      <= '0;
      r_row      <= '0;
      r_wr_en    <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_char  <= CH_SPACE;
      r_busy     <= 1'b0;
      r_overrun  <= 1'b0;
      r_pend_vld <= 1'b0;
    end else begin
      r_col      <= w_col_nxt;
      r_row      <= w_row_nxt;
      r_wr_en    <= w_wr_en_nxt;
      r_wr_addr  <= w_wr_addr_nxt;
      r_wr_char  <= w_wr_char_nxt;
      r_busy     <= w_busy_nxt;
      r_overrun  <= w_overrun_nxt;
      r_pend_vld <= w_pend_vld_nxt;
    end
  end

  // Data-only registers; their contents matter only while qualified by state or valid.
  always_ff @(posedge clk) begin
    r_pend_data <= w_pend_data_nxt;
    r_sw_addr   <= w_sw_addr_nxt;
    r_sw_left   <= w_sw_left_nxt;
  end

  assign bus.wr_en      = r_wr_en;
  assign bus.wr_addr    = r_wr_addr;
  assign bus.wr_char    = r_wr_char;
  assign bus.cursor_col = r_col;
  assign bus.cursor_row = r_row;
  assign bus.busy       = r_busy;
  assign bus.overrun    = r_overrun;

endmodule

// File: tb/tb_text_cursor_ctrl.sv
// Bench for text_cursor_ctrl: directed cycle-exact scenarios followed by a
// randomized byte stream checked against a screen-level reference model.
module tb_text_cursor_ctrl;
  localparam int COLS   = 80;
  localparam int ROWS   = 30;
  localparam int ADDR_W = 12;

  typedef logic [ADDR_W+7:0] wr_t;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  text_cursor_ctrl_if #(.COLS(COLS), .ROWS(ROWS), .ADDR_W(ADDR_W)) bus ();

  text_cursor_ctrl #(.COLS(COLS), .ROWS(ROWS), .ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int  n_checks = 0;
  int  n_errors = 0;
  int  ovr_cnt  = 0;
  wr_t obs_q[$];
  wr_t exp_q[$];
  int  mcol, mrow;

  // Advance one clock and sample the outputs 1 ns after the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
    if (bus.wr_en === 1'b1) obs_q.push_back({bus.wr_addr, bus.wr_char});
    if (bus.overrun === 1'b1) ovr_cnt++;
  endtask

  task automatic send(input logic [7:0] b);
    bus.data_in    = b;
    bus.data_ready = 1'b1;
    cyc();
    bus.data_ready = 1'b0;
  endtask

  task automatic do_reset();
    reset          = 1'b1;
    bus.data_ready = 1'b0;
    cyc();
    cyc();
    reset = 1'b0;
    mcol  = 0;
    mrow  = 0;
  endtask

  task automatic wait_idle(input string tag);
    int guard;
    guard = 0;
    while (bus.busy === 1'b1 && guard < 5000) begin
      cyc();
      guard++;
    end
    n_checks++;
    if (bus.busy !== 1'b0) begin
      n_errors++;
      $display("FAIL %s_idle_timeout: busy=%b, required 0 within 5000 cycles", tag, bus.busy);
    end
  endtask

  // Reference model: applies one byte to a cursor on the character grid and
  // lists the cell writes it implies, in order.
  task automatic model_byte(input logic [7:0] b);
    if (b >= 8'h20 && b <= 8'h7E) begin
      exp_q.push_back({ADDR_W'(mrow * COLS + mcol), b});
      if (mcol == COLS - 1) begin
        mcol = 0;
        mrow = (mrow + 1) % ROWS;
        for (int c = 0; c < COLS; c++) exp_q.push_back({ADDR_W'(mrow * COLS + c), 8'h20});
      end else begin
        mcol = mcol + 1;
      end
    end else if (b == 8'h0D) begin
      mcol = 0;
    end else if (b == 8'h0A) begin
      mcol = 0;
      mrow = (mrow + 1) % ROWS;
      for (int c = 0; c < COLS; c++) exp_q.push_back({ADDR_W'(mrow * COLS + c), 8'h20});
    end else if (b == 8'h08) begin
      if (mcol > 0) begin
        mcol = mcol - 1;
        exp_q.push_back({ADDR_W'(mrow * COLS + mcol), 8'h20});
      end
    end else if (b == 8'h0C) begin
      mcol = 0;
      mrow = 0;
      for (int a = 0; a < COLS * ROWS; a++) exp_q.push_back({ADDR_W'(a), 8'h20});
    end
  endtask

  function automatic logic [7:0] pick_byte();
    logic [7:0] ign [7];
    int r;
    ign = '{8'h00, 8'h01, 8'h07, 8'h09, 8'h0B, 8'h1B, 8'h7F};
    r = $urandom_range(0, 99);
    if (r < 70) return 8'($urandom_range(32, 126));
    if (r < 78) return 8'h0A;
    if (r < 84) return 8'h0D;
    if (r < 92) return 8'h08;
    if (r < 93) return 8'h0C;
    if (r < 96) return 8'($urandom_range(128, 255));
    return ign[$urandom_range(0, 6)];
  endfunction

  task automatic test_reset();
    reset          = 1'b1;
    bus.data_in    = 8'h55;
    bus.data_ready = 1'b1;
    cyc();
    cyc();
    reset          = 1'b0;
    bus.data_ready = 1'b0;
    n_checks++; if (bus.wr_en !== 1'b0)        begin n_errors++; $display("FAIL rst_wr_en: got %b, required 0", bus.wr_en); end
    n_checks++; if (bus.wr_addr !== '0)        begin n_errors++; $display("FAIL rst_wr_addr: got %0d, required 0", bus.wr_addr); end
    n_checks++; if (bus.wr_char !== 8'h20)     begin n_errors++; $display("FAIL rst_wr_char: got %h, required 20", bus.wr_char); end
    n_checks++; if (bus.cursor_col !== '0 || bus.cursor_row !== '0)
      begin n_errors++; $display("FAIL rst_cursor: got (%0d,%0d), required (0,0)", bus.cursor_col, bus.cursor_row); end
    n_checks++; if (bus.busy !== 1'b0)         begin n_errors++; $display("FAIL rst_busy: got %b, required 0", bus.busy); end
    n_checks++; if (bus.overrun !== 1'b0)      begin n_errors++; $display("FAIL rst_overrun: got %b, required 0", bus.overrun); end
    cyc();
    n_checks++; if (bus.wr_en !== 1'b0 || bus.cursor_col !== '0)
      begin n_errors++; $display("FAIL rst_byte_discard: wr_en=%b col=%0d, required 0 and 0", bus.wr_en, bus.cursor_col); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    send(8'h41);
    n_checks++; if (bus.wr_en !== 1'b1 || bus.wr_addr !== 12'd0 || bus.wr_char !== 8'h41 || bus.cursor_col !== 7'd1)
      begin n_errors++; $display("FAIL b2b_first: en=%b addr=%0d char=%h col=%0d, required 1 0 41 1", bus.wr_en, bus.wr_addr, bus.wr_char, bus.cursor_col); end
    send(8'h42);
    n_checks++; if (bus.wr_en !== 1'b1 || bus.wr_addr !== 12'd1 || bus.wr_char !== 8'h42 || bus.cursor_col !== 7'd2 || bus.busy !== 1'b0)
      begin n_errors++; $display("FAIL b2b_second: en=%b addr=%0d char=%h col=%0d busy=%b, required 1 1 42 2 0", bus.wr_en, bus.wr_addr, bus.wr_char, bus.cursor_col, bus.busy); end
    for (int c = 2; c < COLS - 1; c++) begin
      send(8'h30 + 8'(c % 10));
      n_checks++;
      if (bus.wr_en !== 1'b1 || bus.wr_addr !== ADDR_W'(c) || bus.wr_char !== 8'h30 + 8'(c % 10) || bus.cursor_col !== 7'(c + 1)) begin
        n_errors++;
        $display("FAIL b2b_col%0d: en=%b addr=%0d char=%h col=%0d, required 1 %0d %h %0d", c, bus.wr_en, bus.wr_addr, bus.wr_char, bus.cursor_col, c, 8'h30 + 8'(c % 10), c + 1);
      end
    end
  endtask

  task automatic test_wrap();
    send(8'h5A);
    n_checks++; if (bus.wr_en !== 1'b1 || bus.wr_addr !== 12'd79 || bus.wr_char !== 8'h5A || bus.busy !== 1'b0)
      begin n_errors++; $display("FAIL wrap_char: en=%b addr=%0d char=%h busy=%b, required 1 79 5a 0", bus.wr_en, bus.wr_addr, bus.wr_char, bus.busy); end
    n_checks++; if (bus.cursor_col !== 7'd0 || bus.cursor_row !== 5'd1)
      begin n_errors++; $display("FAIL wrap_cursor: got (%0d,%0d), required (0,1)", bus.cursor_col, bus.cursor_row); end
    for (int k = 0; k < COLS; k++) begin
      cyc();
      n_checks++;
      if (bus.busy !== 1'b1 || bus.wr_en !== 1'b1 || bus.wr_addr !== ADDR_W'(80 + k) || bus.wr_char !== 8'h20) begin
        n_errors++;
        $display("FAIL wrap_blank%0d: busy=%b en=%b addr=%0d char=%h, required 1 1 %0d 20", k, bus.busy, bus.wr_en, bus.wr_addr, bus.wr_char, 80 + k);
      end
    end
    cyc();
    n_checks++; if (bus.busy !== 1'b0 || bus.wr_en !== 1'b0)
      begin n_errors++; $display("FAIL wrap_end: busy=%b en=%b, required 0 0", bus.busy, bus.wr_en); end
  endtask

  task automatic test_lf_last_row();
    for (int r = 1; r < ROWS - 1; r++) begin
      send(8'h0A);
      wait_idle("lf_walk");
    end
    n_checks++; if (bus.cursor_row !== 5'd29 || bus.cursor_col !== 7'd0)
      begin n_errors++; $display("FAIL lf_walk_cursor: got (%0d,%0d), required (0,29)", bus.cursor_col, bus.cursor_row); end
    send(8'h0A);
    n_checks++; if (bus.cursor_row !== 5'd0 || bus.cursor_col !== 7'd0)
      begin n_errors++; $display("FAIL lf_wrap_cursor: got (%0d,%0d), required (0,0)", bus.cursor_col, bus.cursor_row); end
    for (int k = 0; k < COLS; k++) begin
      if (k > 0) cyc();
      n_checks++;
      if (bus.busy !== 1'b1 || bus.wr_en !== 1'b1 || bus.wr_addr !== ADDR_W'(k) || bus.wr_char !== 8'h20) begin
        n_errors++;
        $display("FAIL lf_blank%0d: busy=%b en=%b addr=%0d char=%h, required 1 1 %0d 20", k, bus.busy, bus.wr_en, bus.wr_addr, bus.wr_char, k);
      end
    end
    cyc();
    n_checks++; if (bus.busy !== 1'b0 || bus.wr_en !== 1'b0)
      begin n_errors++; $display("FAIL lf_end: busy=%b en=%b, required 0 0", bus.busy, bus.wr_en); end
  endtask

  task automatic test_backspace();
    send(8'h0A); wait_idle("bs_lf1");
    send(8'h0A); wait_idle("bs_lf2");
    for (int i = 0; i < 5; i++) send(8'h61 + 8'(i));
    send(8'h08);
    n_checks++; if (bus.wr_en !== 1'b1 || bus.wr_addr !== 12'd164 || bus.wr_char !== 8'h20 || bus.cursor_col !== 7'd4 || bus.cursor_row !== 5'd2)
      begin n_errors++; $display("FAIL bs_write: en=%b addr=%0d char=%h cur=(%0d,%0d), required 1 164 20 (4,2)", bus.wr_en, bus.wr_addr, bus.wr_char, bus.cursor_col, bus.cursor_row); end
    send(8'h0D);
    n_checks++; if (bus.wr_en !== 1'b0 || bus.cursor_col !== 7'd0 || bus.cursor_row !== 5'd2)
      begin n_errors++; $display("FAIL cr: en=%b cur=(%0d,%0d), required 0 (0,2)", bus.wr_en, bus.cursor_col, bus.cursor_row); end
    send(8'h08);
    n_checks++; if (bus.wr_en !== 1'b0 || bus.cursor_col !== 7'd0 || bus.cursor_row !== 5'd2)
      begin n_errors++; $display("FAIL bs_col0: en=%b cur=(%0d,%0d), required 0 (0,2)", bus.wr_en, bus.cursor_col, bus.cursor_row); end
    send(8'h07);
    cyc();
    n_checks++; if (bus.wr_en !== 1'b0 || bus.busy !== 1'b0 || bus.cursor_col !== 7'd0)
      begin n_errors++; $display("FAIL ignored_byte: en=%b busy=%b col=%0d, required 0 0 0", bus.wr_en, bus.busy, bus.cursor_col); end
  endtask

  task automatic test_ff_overrun();
    ovr_cnt = 0;
    send(8'h0C);
    n_checks++; if (bus.cursor_col !== 7'd0 || bus.cursor_row !== 5'd0)
      begin n_errors++; $display("FAIL ff_cursor: got (%0d,%0d), required (0,0)", bus.cursor_col, bus.cursor_row); end
    for (int k = 0; k < COLS * ROWS; k++) begin
      n_checks++;
      if (bus.busy !== 1'b1 || bus.wr_en !== 1'b1 || bus.wr_addr !== ADDR_W'(k) || bus.wr_char !== 8'h20) begin
        n_errors++;
        $display("FAIL ff_blank%0d: busy=%b en=%b addr=%0d char=%h, required 1 1 %0d 20", k, bus.busy, bus.wr_en, bus.wr_addr, bus.wr_char, k);
      end
      if (k == 2) begin
        n_checks++;
        if (bus.overrun !== 1'b1) begin n_errors++; $display("FAIL ff_overrun_pulse: got %b, required 1", bus.overrun); end
      end
      if (k == 0) begin bus.data_in = 8'h31; bus.data_ready = 1'b1; end
      else if (k == 1) begin bus.data_in = 8'h32; bus.data_ready = 1'b1; end
      else bus.data_ready = 1'b0;
      cyc();
    end
    n_checks++; if (bus.busy !== 1'b0 || bus.wr_en !== 1'b0)
      begin n_errors++; $display("FAIL ff_end: busy=%b en=%b, required 0 0", bus.busy, bus.wr_en); end
    cyc();
    n_checks++; if (bus.wr_en !== 1'b1 || bus.wr_addr !== 12'd0 || bus.wr_char !== 8'h31 || bus.cursor_col !== 7'd1)
      begin n_errors++; $display("FAIL ff_pending: en=%b addr=%0d char=%h col=%0d, required 1 0 31 1", bus.wr_en, bus.wr_addr, bus.wr_char, bus.cursor_col); end
    cyc();
    n_checks++; if (bus.wr_en !== 1'b0)
      begin n_errors++; $display("FAIL ff_dropped: en=%b char=%h, required no write", bus.wr_en, bus.wr_char); end
    n_checks++; if (ovr_cnt !== 1)
      begin n_errors++; $display("FAIL ff_overrun_count: got %0d, required 1", ovr_cnt); end
  endtask

  task automatic test_pending_replace();
    ovr_cnt = 0;
    send(8'h0A);
    for (int k = 0; k < COLS; k++) begin
      n_checks++;
      if (bus.wr_en !== 1'b1 || bus.wr_addr !== ADDR_W'(80 + k)) begin
        n_errors++;
        $display("FAIL pend_blank%0d: en=%b addr=%0d, required 1 %0d", k, bus.wr_en, bus.wr_addr, 80 + k);
      end
      if (k == 10) begin bus.data_in = 8'h61; bus.data_ready = 1'b1; end
      else bus.data_ready = 1'b0;
      cyc();
    end
    n_checks++; if (bus.busy !== 1'b0)
      begin n_errors++; $display("FAIL pend_idle: busy=%b, required 0", bus.busy); end
    send(8'h62);
    n_checks++; if (bus.wr_en !== 1'b1 || bus.wr_addr !== 12'd80 || bus.wr_char !== 8'h61)
      begin n_errors++; $display("FAIL pend_first: en=%b addr=%0d char=%h, required 1 80 61", bus.wr_en, bus.wr_addr, bus.wr_char); end
    cyc();
    n_checks++; if (bus.wr_en !== 1'b1 || bus.wr_addr !== 12'd81 || bus.wr_char !== 8'h62 || bus.cursor_col !== 7'd2)
      begin n_errors++; $display("FAIL pend_second: en=%b addr=%0d char=%h col=%0d, required 1 81 62 2", bus.wr_en, bus.wr_addr, bus.wr_char, bus.cursor_col); end
    n_checks++; if (ovr_cnt !== 0)
      begin n_errors++; $display("FAIL pend_no_overrun: got %0d pulses, required 0", ovr_cnt); end
  endtask

  task automatic test_reset_mid_sweep();
    send(8'h0C);
    bus.data_in    = 8'h39;
    bus.data_ready = 1'b1;
    cyc();
    bus.data_ready = 1'b0;
    for (int k = 0; k < 100; k++) cyc();
    reset          = 1'b1;
    bus.data_in    = 8'h45;
    bus.data_ready = 1'b1;
    cyc();
    reset          = 1'b0;
    bus.data_ready = 1'b0;
    n_checks++; if (bus.wr_en !== 1'b0 || bus.busy !== 1'b0 || bus.overrun !== 1'b0)
      begin n_errors++; $display("FAIL midrst_ctrl: en=%b busy=%b ovr=%b, required 0 0 0", bus.wr_en, bus.busy, bus.overrun); end
    n_checks++; if (bus.cursor_col !== '0 || bus.cursor_row !== '0 || bus.wr_addr !== '0 || bus.wr_char !== 8'h20)
      begin n_errors++; $display("FAIL midrst_vals: cur=(%0d,%0d) addr=%0d char=%h, required (0,0) 0 20", bus.cursor_col, bus.cursor_row, bus.wr_addr, bus.wr_char); end
    cyc();
    n_checks++; if (bus.wr_en !== 1'b0 || bus.busy !== 1'b0)
      begin n_errors++; $display("FAIL midrst_no_resume: en=%b busy=%b, required 0 0", bus.wr_en, bus.busy); end
    send(8'h41);
    n_checks++; if (bus.wr_en !== 1'b1 || bus.wr_addr !== 12'd0 || bus.wr_char !== 8'h41)
      begin n_errors++; $display("FAIL midrst_after: en=%b addr=%0d char=%h, required 1 0 41", bus.wr_en, bus.wr_addr, bus.wr_char); end
  endtask

  task automatic test_random();
    logic [7:0] b;
    int         bad_idx;
    logic       bad;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      b = pick_byte();
      exp_q.delete();
      obs_q.delete();
      model_byte(b);
      send(b);
      cyc();
      wait_idle("rand");
      bad     = 1'b0;
      bad_idx = -1;
      if (obs_q.size() != exp_q.size()) bad = 1'b1;
      else begin
        for (int j = 0; j < exp_q.size(); j++) begin
          if (obs_q[j] !== exp_q[j]) begin bad = 1'b1; bad_idx = j; break; end
        end
      end
      n_checks++;
      if (bad) begin
        n_errors++;
        if (bad_idx >= 0)
          $display("FAIL rand_writes byte %0d (%h): write %0d got addr %0d char %h, required addr %0d char %h", i, b, bad_idx,
                   obs_q[bad_idx][ADDR_W+7:8], obs_q[bad_idx][7:0], exp_q[bad_idx][ADDR_W+7:8], exp_q[bad_idx][7:0]);
        else
          $display("FAIL rand_writes byte %0d (%h): got %0d writes, required %0d", i, b, obs_q.size(), exp_q.size());
      end
      n_checks++;
      if (int'(bus.cursor_col) != mcol || int'(bus.cursor_row) != mrow) begin
        n_errors++;
        $display("FAIL rand_cursor byte %0d (%h): got (%0d,%0d), required (%0d,%0d)", i, b, bus.cursor_col, bus.cursor_row, mcol, mrow);
      end
      repeat ($urandom_range(0, 2)) cyc();
    end
  endtask

  initial begin
    reset          = 1'b1;
    bus.data_in    = 8'h00;
    bus.data_ready = 1'b0;
    test_reset();
    test_back_to_back();
    test_wrap();
    test_lf_last_row();
    test_backspace();
    test_ff_overrun();
    test_pending_replace();
    test_reset_mid_sweep();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation exceeded 3000000 ns, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
